// File: rtl/codificador_teclado_pkg.sv
// Shared constants and types for the keypad scan encoder.
// The group and line geometry matches the BCD decoder on the output side.
package codificador_teclado_pkg;

    localparam int NUM_GROUPS = 3;
    localparam int NUM_LINES  = 4;
    localparam int MAX_DIGIT  = 9;
    localparam int SEL_BASE   = 4;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_SCAN         = 2'd1,
        ST_CONFIRM      = 2'd2,
        ST_WAIT_RELEASE = 2'd3
    } estado_t;

    typedef enum logic [1:0] {
        RES_NONE = 2'd0,
        RES_KEY  = 2'd1,
        RES_BAD  = 2'd2
    } resultado_t;

    // Digit for a key at (group, line): 4*g + a.
    function automatic logic [3:0] codigo_tecla(input logic [1:0] grupo, input logic [1:0] linea);
        return 4'(grupo) * 4'(NUM_LINES) + 4'(linea);
    endfunction

endpackage

// File: rtl/codificador_teclado_sincronizador_lineas.sv
// Two-flop synchronizer for the raw keypad sense lines.
module sincronizador_lineas
    import codificador_teclado_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_LINES-1:0] line_in,
    output logic [NUM_LINES-1:0] line_sync
);

    logic [NUM_LINES-1:0] meta_q;
    logic [NUM_LINES-1:0] sync_q;

    for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_bit
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                meta_q[gi] <= 1'b0;
                sync_q[gi] <= 1'b0;
            end else begin
                meta_q[gi] <= line_in[gi];
                sync_q[gi] <= meta_q[gi];
            end
        end
    end

    assign line_sync = sync_q;

endmodule

// File: rtl/codificador_teclado.sv
// Keypad scan encoder: drives one select group at a time, debounces a single
// press and emits its BCD digit with a one-cycle key_valid pulse.
module codificador_teclado
    import codificador_teclado_pkg::*;
#(
    parameter int SCAN_CYCLES = 1000,
    parameter int DEBOUNCE    = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [3:0] line_in,
    output logic [2:0] sel_out,
    output logic [3:0] bcd_num,
    output logic       key_valid,
    output logic       busy
);

    localparam int SLOT_W = $clog2(SCAN_CYCLES);
    localparam int DEB_W  = $clog2(DEBOUNCE + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SCAN_CYCLES - 1);
    localparam logic [DEB_W-1:0]  DEB_TARGET = DEB_W'(DEBOUNCE);
    localparam logic [1:0]        GROUP_LAST = 2'(NUM_GROUPS - 1);

    estado_t           state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [1:0]        group_q, group_d;
    logic [1:0]        seen_q, seen_d;
    logic [3:0]        code_q, code_d;
    logic [3:0]        cand_q, cand_d;
    logic [DEB_W-1:0]  deb_q, deb_d;
    logic [DEB_W-1:0]  rel_q, rel_d;
    logic [3:0]        bcd_q, bcd_d;
    logic              kv_q, kv_d;

    logic [3:0] line_sync;
    logic [2:0] pop;
    logic [1:0] idx;
    logic [2:0] seen_total;
    logic [3:0] code_all;
    resultado_t result;
    logic       accept;
    logic [3:0] acc_code;

    sincronizador_lineas u_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .line_in  (line_in),
        .line_sync(line_sync)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            slot_q  <= '0;
            group_q <= '0;
            seen_q  <= '0;
            code_q  <= '0;
            cand_q  <= '0;
            deb_q   <= '0;
            rel_q   <= '0;
            bcd_q   <= '0;
            kv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            group_q <= group_d;
            seen_q  <= seen_d;
            code_q  <= code_d;
            cand_q  <= cand_d;
            deb_q   <= deb_d;
            rel_q   <= rel_d;
            bcd_q   <= bcd_d;
            kv_q    <= kv_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        group_d  = group_q;
        seen_d   = seen_q;
        code_d   = code_q;
        cand_d   = cand_q;
        deb_d    = deb_q;
        rel_d    = rel_q;
        bcd_d    = bcd_q;
        kv_d     = 1'b0;
        accept   = 1'b0;
        acc_code = cand_q;

        pop = 3'd0;
        idx = 2'd0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (line_sync[i]) begin
                pop = pop + 3'd1;
                idx = 2'(i);
            end
        end
        // Round tally including the sample taken on this cycle.
        seen_total = 3'(seen_q) + pop;
        code_all   = (pop == 3'd1) ? codigo_tecla(group_q, idx) : code_q;
        if (seen_total == 3'd0)
            result = RES_NONE;
        else if (seen_total == 3'd1 && code_all <= 4'(MAX_DIGIT))
            result = RES_KEY;
        else
            result = RES_BAD;

        if (!enable || state_q == ST_IDLE) begin
            state_d = enable ? ST_SCAN : ST_IDLE;
            slot_d  = '0;
            group_d = '0;
            seen_d  = '0;
            code_d  = '0;
            deb_d   = '0;
            rel_d   = '0;
        end else if (slot_q != SLOT_LAST) begin
            slot_d = slot_q + SLOT_W'(1);
        end else begin
            slot_d  = '0;
            group_d = (group_q == GROUP_LAST) ? 2'd0 : group_q + 2'd1;
            if (group_q != GROUP_LAST) begin
                seen_d = (seen_total >= 3'd2) ? 2'd2 : seen_total[1:0];
                code_d = code_all;
            end else begin
                seen_d = '0;
                code_d = '0;
                case (state_q)
                    ST_SCAN: begin
                        if (result == RES_KEY) begin
                            cand_d = code_all;
                            deb_d  = DEB_W'(1);
                            if (DEB_TARGET == DEB_W'(1)) begin
                                accept   = 1'b1;
                                acc_code = code_all;
                            end else begin
                                state_d = ST_CONFIRM;
                            end
                        end
                    end
                    ST_CONFIRM: begin
                        if (result == RES_KEY && code_all == cand_q) begin
                            deb_d = deb_q + DEB_W'(1);
                            if (deb_q + DEB_W'(1) == DEB_TARGET)
                                accept = 1'b1;
                        end else begin
                            state_d = ST_SCAN;
                            deb_d   = '0;
                        end
                    end
                    ST_WAIT_RELEASE: begin
                        if (result == RES_NONE) begin
                            rel_d = rel_q + DEB_W'(1);
                            if (rel_q + DEB_W'(1) == DEB_TARGET) begin
                                state_d = ST_SCAN;
                                rel_d   = '0;
                            end
                        end else begin
                            rel_d = '0;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
                if (accept) begin
                    bcd_d   = acc_code;
                    kv_d    = 1'b1;
                    state_d = ST_WAIT_RELEASE;
                    deb_d   = '0;
                    rel_d   = '0;
                end
            end
        end
    end

    always_comb begin
        sel_out   = (state_q == ST_IDLE) ? 3'b000 : 3'(3'b001 << group_q);
        busy      = (state_q == ST_CONFIRM) || (state_q == ST_WAIT_RELEASE);
        bcd_num   = bcd_q;
        key_valid = kv_q;
    end

endmodule

// File: tb/tb_codificador_teclado.sv
// Bench for codificador_teclado: a key-matrix model drives the sense lines and
// a scoreboard checks every key_valid pulse against the queued expected digit.
module tb_codificador_teclado;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic [3:0] line_in;
    logic [2:0] sel_out;
    logic [3:0] bcd_num;
    logic       key_valid;
    logic       busy;

    logic [11:0] keys;
    logic [3:0]  exp_q[$];
    int checks;
    int failures;

    codificador_teclado #(.SCAN_CYCLES(4), .DEBOUNCE(2)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .line_in  (line_in),
        .sel_out  (sel_out),
        .bcd_num  (bcd_num),
        .key_valid(key_valid),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pressed key (g,a) connects select group g to sense line a.
    always_comb begin
        line_in = 4'b0000;
        for (int g = 0; g < 3; g++)
            for (int a = 0; a < 4; a++)
                if (keys[g*4+a] && sel_out[g]) line_in[a] = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic rounds(input int n);
        repeat (12 * n) @(posedge clk);
        #1;
    endtask

    task automatic queue_drained(input string name);
        chk(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Scoreboard monitor: every key_valid pulse must match a queued digit.
    always @(negedge clk) begin
        if (reset_n && key_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_key_valid actual=%0h required=no pulse", bcd_num);
            end else begin
                automatic logic [3:0] e = exp_q.pop_front();
                if (bcd_num !== e) begin
                    failures++;
                    $display("FAIL key_digit actual=%0h required=%0h", bcd_num, e);
                end else begin
                    $display("key_valid bcd_num=%0h", bcd_num);
                end
            end
        end
    end

    initial begin
        checks = 0;
        failures = 0;
        keys = '0;
        enable = 1'b0;
        reset_n = 1'b0;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        chk("reset_sel", 32'(sel_out), 32'd0);
        chk("reset_bcd", 32'(bcd_num), 32'd0);
        chk("reset_kv", 32'(key_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            repeat (5) @(negedge clk);
            chk("idle_sel", 32'(sel_out), 32'd0);
            chk("idle_kv", 32'(key_valid), 32'd0);
        end

        enable = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("scan_sel", 32'(sel_out), 32'(3'b001 << (i / 4)));
        end
        @(posedge clk);
        #1;
        chk("scan_wrap_sel", 32'(sel_out), 32'd1);

        // Digit 7: group 1 line 3 for 3 rounds
        keys[7] = 1'b1;
        rounds(1);
        chk("d7_busy_confirm", 32'(busy), 32'd1);
        exp_q.push_back(4'h7);
        rounds(2);
        keys = '0;
        chk("d7_bcd", 32'(bcd_num), 32'h7);
        rounds(1);
        chk("d7_busy_release1", 32'(busy), 32'd1);
        rounds(1);
        chk("d7_busy_release2", 32'(busy), 32'd0);
        queue_drained("d7_pulse_count");

        // Bounce: group 0 line 1 present, absent, present twice
        keys[1] = 1'b1;
        rounds(1);
        keys = '0;
        rounds(1);
        chk("bounce_back_to_scan", 32'(busy), 32'd0);
        keys[1] = 1'b1;
        rounds(1);
        exp_q.push_back(4'h1);
        rounds(1);
        keys = '0;
        chk("bounce_bcd", 32'(bcd_num), 32'h1);
        rounds(2);
        queue_drained("bounce_pulse_count");

        // Invalid code 11 and ghosting
        keys[11] = 1'b1;
        rounds(5);
        chk("code11_busy", 32'(busy), 32'd0);
        keys = '0;
        rounds(1);
        keys[0] = 1'b1;
        keys[1] = 1'b1;
        rounds(3);
        chk("ghost_busy", 32'(busy), 32'd0);
        keys = '0;
        rounds(1);
        chk("invalid_bcd_held", 32'(bcd_num), 32'h1);
        queue_drained("invalid_no_pulse");

        // Held digit 9 (group 2 line 1), then second press
        keys[9] = 1'b1;
        rounds(1);
        exp_q.push_back(4'h9);
        rounds(9);
        chk("held_busy", 32'(busy), 32'd1);
        keys = '0;
        rounds(2);
        chk("held_released", 32'(busy), 32'd0);
        keys[9] = 1'b1;
        rounds(1);
        exp_q.push_back(4'h9);
        rounds(1);
        keys = '0;
        chk("held_bcd", 32'(bcd_num), 32'h9);
        rounds(2);
        queue_drained("held_pulse_count");

        // Disable mid-confirm with digit 5 held
        keys[5] = 1'b1;
        rounds(1);
        chk("dis_confirm_busy", 32'(busy), 32'd1);
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("dis_sel", 32'(sel_out), 32'd0);
        chk("dis_busy", 32'(busy), 32'd0);
        repeat (15) @(negedge clk);
        chk("dis_bcd_held", 32'(bcd_num), 32'h9);
        enable = 1'b1;
        @(posedge clk);
        #1;
        rounds(1);
        exp_q.push_back(4'h5);
        rounds(1);
        keys = '0;
        chk("reenable_bcd", 32'(bcd_num), 32'h5);
        rounds(2);
        queue_drained("reenable_pulse_count");

        // Reset mid-round during confirm of digit 3
        keys[3] = 1'b1;
        rounds(1);
        chk("rst_confirm_busy", 32'(busy), 32'd1);
        repeat (5) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_bcd", 32'(bcd_num), 32'd0);
        chk("rst_sel", 32'(sel_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_kv", 32'(key_valid), 32'd0);
        keys = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("post_rst_bcd", 32'(bcd_num), 32'd0);
        queue_drained("final_queue");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
